// File: rtl/ac_motor_pwm_core.sv
// Single-phase sine-triangle PWM core: triangle carrier, 3-phase sine reference, H-bridge comparator.
// Optional dead time on the bridge enables when AC_MOTOR_DEADTIME_EN is defined.
//
// Triangle FSM
//   state     | meaning
//   TRI_START | first clk after reset: carrier held at valley, lock asserted
//   TRI_UP    | carrier rising by TRI_STEP per clk
//   TRI_DOWN  | carrier falling by TRI_STEP per clk
module ac_motor_pwm_core #(
   parameter int TRI_PEAK    = 2**23,
   parameter int TRI_STEP    = 8192,
   parameter int PH2_OFS     = 21845,
   parameter int PH3_OFS     = 43691,
   parameter int DEAD_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               cw_in,
   input  logic               ccw_in,
   input  logic [12:0]        frequency,
   input  logic signed [12:0] amplitude,
   output logic               cw_out,
   output logic               ccw_out,
   output logic               lock,
   output logic signed [24:0] triangle,
   output logic signed [23:0] sine1,
   output logic signed [23:0] sine2,
   output logic signed [23:0] sine3,
   output logic               out1,
   output logic               out2,
   output logic               en1,
   output logic               en2
);

   localparam logic signed [24:0] PEAK = 25'(TRI_PEAK);
   localparam logic signed [24:0] STEP = 25'(TRI_STEP);
   localparam logic [15:0]        PH2  = 16'(PH2_OFS);
   localparam logic [15:0]        PH3  = 16'(PH3_OFS);

   typedef enum logic [1:0] {
      TRI_START,
      TRI_UP,
      TRI_DOWN
   } tri_state_t;

   tri_state_t         state_q;
   logic signed [24:0] tri_q;
   logic               lock_q;
   logic               lock_dly_q;
   logic               cw_q;
   logic               ccw_q;
   logic [15:0]        phase_q;
   logic signed [23:0] sine1_q;
   logic signed [23:0] sine2_q;
   logic signed [23:0] sine3_q;
   logic               out1_q;
   logic               out2_q;
   logic               en_q;

   // Quarter-wave table: round(2047 * sin(2*pi*k/256)), k = 0..63.
   function automatic logic [10:0] quarter_rom(input logic [5:0] k);
      logic [10:0] q;
      q = '0;
      case (k)
         6'd0:  q = 11'd0;
         6'd1:  q = 11'd50;
         6'd2:  q = 11'd100;
         6'd3:  q = 11'd151;
         6'd4:  q = 11'd201;
         6'd5:  q = 11'd251;
         6'd6:  q = 11'd300;
         6'd7:  q = 11'd350;
         6'd8:  q = 11'd399;
         6'd9:  q = 11'd449;
         6'd10: q = 11'd497;
         6'd11: q = 11'd546;
         6'd12: q = 11'd594;
         6'd13: q = 11'd642;
         6'd14: q = 11'd690;
         6'd15: q = 11'd737;
         6'd16: q = 11'd783;
         6'd17: q = 11'd830;
         6'd18: q = 11'd875;
         6'd19: q = 11'd920;
         6'd20: q = 11'd965;
         6'd21: q = 11'd1009;
         6'd22: q = 11'd1052;
         6'd23: q = 11'd1095;
         6'd24: q = 11'd1137;
         6'd25: q = 11'd1179;
         6'd26: q = 11'd1219;
         6'd27: q = 11'd1259;
         6'd28: q = 11'd1299;
         6'd29: q = 11'd1337;
         6'd30: q = 11'd1375;
         6'd31: q = 11'd1411;
         6'd32: q = 11'd1447;
         6'd33: q = 11'd1483;
         6'd34: q = 11'd1517;
         6'd35: q = 11'd1550;
         6'd36: q = 11'd1582;
         6'd37: q = 11'd1614;
         6'd38: q = 11'd1644;
         6'd39: q = 11'd1674;
         6'd40: q = 11'd1702;
         6'd41: q = 11'd1729;
         6'd42: q = 11'd1756;
         6'd43: q = 11'd1781;
         6'd44: q = 11'd1805;
         6'd45: q = 11'd1828;
         6'd46: q = 11'd1850;
         6'd47: q = 11'd1871;
         6'd48: q = 11'd1891;
         6'd49: q = 11'd1910;
         6'd50: q = 11'd1927;
         6'd51: q = 11'd1944;
         6'd52: q = 11'd1959;
         6'd53: q = 11'd1973;
         6'd54: q = 11'd1986;
         6'd55: q = 11'd1997;
         6'd56: q = 11'd2008;
         6'd57: q = 11'd2017;
         6'd58: q = 11'd2025;
         6'd59: q = 11'd2032;
         6'd60: q = 11'd2037;
         6'd61: q = 11'd2041;
         6'd62: q = 11'd2045;
         6'd63: q = 11'd2046;
         default: q = '0;
      endcase
      return q;
   endfunction

   // Index 64 (the crest) is not in the quarter table, so it is supplied directly.
   function automatic logic signed [11:0] sine_lut(input logic [7:0] idx);
      logic [5:0]  a;
      logic [10:0] mag;
      a = idx[5:0];
      if (idx[6]) mag = (a == 6'd0) ? 11'd2047 : quarter_rom(6'd0 - a);
      else        mag = quarter_rom(a);
      return idx[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
   endfunction

   function automatic logic signed [23:0] scale(input logic signed [12:0] amp,
                                                input logic [15:0] ph);
      logic signed [24:0] prod;
      prod = 25'(amp) * 25'(sine_lut(ph[15:8]));
      return prod[23:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= TRI_START;
         tri_q   <= -PEAK;
         lock_q  <= 1'b0;
      end else begin
         lock_q <= 1'b0;
         case (state_q)
            TRI_START: begin
               state_q <= TRI_UP;
               lock_q  <= 1'b1;
            end
            TRI_UP: begin
               tri_q <= tri_q + STEP;
               if (tri_q + STEP >= PEAK) state_q <= TRI_DOWN;
            end
            TRI_DOWN: begin
               tri_q <= tri_q - STEP;
               if (tri_q - STEP <= -PEAK) begin
                  state_q <= TRI_UP;
                  lock_q  <= 1'b1;
               end
            end
            default: state_q <= TRI_START;
         endcase
      end
   end

   // Direction and phase advance once per carrier valley; sine follows one clk later.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cw_q       <= 1'b0;
         ccw_q      <= 1'b0;
         phase_q    <= '0;
         lock_dly_q <= 1'b0;
         sine1_q    <= '0;
         sine2_q    <= '0;
         sine3_q    <= '0;
      end else begin
         lock_dly_q <= lock_q;
         if (lock_q) begin
            cw_q    <= cw_in & ~ccw_in;
            ccw_q   <= ccw_in & ~cw_in;
            phase_q <= phase_q + {3'b000, frequency};
         end
         if (lock_dly_q) begin
            sine1_q <= scale(amplitude, phase_q);
            sine2_q <= scale(amplitude, phase_q + PH2);
            sine3_q <= scale(amplitude, phase_q + PH3);
         end
      end
   end

   logic gt;
   logic bridge_on;
   logic out1_d;
   logic out2_d;
   logic en_d;

   assign gt        = $signed({sine1_q[23], sine1_q}) > tri_q;
   assign bridge_on = enable & (cw_q ^ ccw_q);
   assign out1_d    = bridge_on & (cw_q ? gt : ~gt);
   assign out2_d    = bridge_on & (cw_q ? ~gt : gt);

`ifdef AC_MOTOR_DEADTIME_EN
   logic [7:0] dead_q;
   logic [7:0] dead_d;

   // Down-counter reloaded on every out1 edge; enables return at terminal count.
   always_comb begin
      dead_d = dead_q;
      if (out1_d != out1_q)     dead_d = 8'(DEAD_CYCLES);
      else if (dead_q != 8'd0)  dead_d = dead_q - 8'd1;
   end

   assign en_d = bridge_on & (dead_d == 8'd0);

   always_ff @(posedge clk) begin
      if (!reset_n) dead_q <= '0;
      else          dead_q <= dead_d;
   end
`else
   assign en_d = bridge_on;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out1_q <= 1'b0;
         out2_q <= 1'b0;
         en_q   <= 1'b0;
      end else begin
         out1_q <= out1_d;
         out2_q <= out2_d;
         en_q   <= en_d;
      end
   end

   assign triangle = tri_q;
   assign lock     = lock_q;
   assign cw_out   = cw_q;
   assign ccw_out  = ccw_q;
   assign sine1    = sine1_q;
   assign sine2    = sine2_q;
   assign sine3    = sine3_q;
   assign out1     = out1_q;
   assign out2     = out2_q;
   assign en1      = en_q;
   assign en2      = en_q;

endmodule

// File: tb/tb_ac_motor_pwm_core.sv
// Directed bench for ac_motor_pwm_core: per-clk checks of carrier, direction and bridge,
// plus a queue of expected sine values pushed at each valley and popped 2 clk later.
module tb_ac_motor_pwm_core;

   localparam longint PEAK    = 8388608;
   localparam longint STEP    = 8192;
   localparam int     PERIOD  = 4096;
   localparam logic [15:0] PH2 = 16'd21845;
   localparam logic [15:0] PH3 = 16'd43691;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               enable = 1'b0;
   logic               cw_in = 1'b0;
   logic               ccw_in = 1'b0;
   logic [12:0]        frequency = '0;
   logic signed [12:0] amplitude = '0;
   logic               cw_out, ccw_out, lock;
   logic signed [24:0] triangle;
   logic signed [23:0] sine1, sine2, sine3;
   logic               out1, out2, en1, en2;

   ac_motor_pwm_core dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .cw_in(cw_in), .ccw_in(ccw_in),
      .frequency(frequency), .amplitude(amplitude),
      .cw_out(cw_out), .ccw_out(ccw_out), .lock(lock), .triangle(triangle),
      .sine1(sine1), .sine2(sine2), .sine3(sine3),
      .out1(out1), .out2(out2), .en1(en1), .en2(en2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                 due;
      logic signed [23:0] s1;
      logic signed [23:0] s2;
      logic signed [23:0] s3;
   } exp_t;

   exp_t               sb[$];
   exp_t               cur;
   int                 n_checks = 0;
   int                 n_errors = 0;
   int                 cyc = 0;
   int                 last_lock = -1;
   int                 dlow = 0;
   bit                 p_lock = 1'b0;
   bit                 p_rst = 1'b1;
   logic signed [23:0] p_sine1 = '0;
   logic signed [24:0] p_tri = '0;
   logic               p_out1 = 1'b0;
   logic               m_cw = 1'b0;
   logic               m_ccw = 1'b0;
   logic [15:0]        m_phase = '0;
   longint             tri_min = 0;
   longint             tri_max = 0;
   longint             s1_max = -1;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int lut_ref(input int idx);
      real v;
      v = 2047.0 * $sin(2.0 * 3.14159265358979 * idx / 256.0);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

   function automatic logic signed [23:0] sine_ref(input logic signed [12:0] amp, input logic [15:0] ph);
      int p;
      p = int'(amp) * lut_ref(int'(ph[15:8]));
      return 24'(p);
   endfunction

   task automatic tick();
      logic   gt, base, e1, e2, een;
      longint d;
      exp_t   e;
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
         chk("rst_triangle", triangle, -PEAK);
         chk("rst_flags", {lock, cw_out, ccw_out, out1, out2, en1, en2}, 0);
         m_cw = 1'b0; m_ccw = 1'b0; m_phase = '0; dlow = 0;
         last_lock = -1;
         sb.delete();
         cur = '{0, '0, '0, '0};
      end else begin
         chk("lock_at_valley", lock, (triangle == -PEAK));
         if (!p_rst) begin
            d = longint'(triangle) - longint'(p_tri);
            chk("tri_step", (d < 0) ? -d : d, STEP);
         end
         if (triangle < tri_min) tri_min = triangle;
         if (triangle > tri_max) tri_max = triangle;
         if (sine1 > s1_max) s1_max = sine1;
         if (lock) begin
            if (last_lock >= 0) chk("lock_period", cyc - last_lock, PERIOD);
            last_lock = cyc;
         end
         base = enable && (m_cw != m_ccw);
         gt   = p_sine1 > p_tri;
         e1   = base && (m_cw ? gt : !gt);
         e2   = base && (m_cw ? !gt : gt);
`ifdef AC_MOTOR_DEADTIME_EN
         if (out1 !== p_out1) dlow = 4;
         een = base && (dlow == 0);
         if (dlow > 0) dlow--;
`else
         een = base;
`endif
         chk("out1", out1, e1);
         chk("out2", out2, e2);
         chk("en1", en1, een);
         chk("en2", en2, een);
         chk("no_shoot_through", out1 & out2, 0);
         if (p_lock) begin
            m_cw  = cw_in && !ccw_in;
            m_ccw = ccw_in && !cw_in;
         end
         chk("cw_out", cw_out, m_cw);
         chk("ccw_out", ccw_out, m_ccw);
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            cur = e;
         end
         if (lock) begin
            m_phase = m_phase + {3'b000, frequency};
            sb.push_back('{cyc + 2, sine_ref(amplitude, m_phase),
                           sine_ref(amplitude, m_phase + PH2), sine_ref(amplitude, m_phase + PH3)});
         end
      end
      chk("sine1", sine1, cur.s1);
      chk("sine2", sine2, cur.s2);
      chk("sine3", sine3, cur.s3);
      p_lock  = lock;
      p_rst   = !reset_n;
      p_sine1 = sine1;
      p_tri   = triangle;
      p_out1  = out1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_lock();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!lock && n < 5000);
      chk("wait_lock", lock, 1);
   endtask

   initial begin
      cur = '{0, '0, '0, '0};
      reset_n   = 1'b0;
      amplitude = 13'sd4095;
      frequency = 13'd4096;
      cw_in     = 1'b1;
      ccw_in    = 1'b0;
      enable    = 1'b1;
      run(4);
      reset_n = 1'b1;
      tick();
      chk("first_lock", lock, 1);
      chk("first_triangle", triangle, -PEAK);

      // free run across four valleys: phase reaches the crest index
      run(4 * PERIOD + 100);
      chk("tri_max", tri_max, PEAK);
      chk("tri_min", tri_min, -PEAK);
      chk("sine1_peak", s1_max, 8382465);

      // direction changes mid-period take effect only after the next valley
      run(2000);
      cw_in = 1'b0; ccw_in = 1'b1;
      wait_lock();
      run(3);
      chk("dir_ccw", {cw_out, ccw_out}, 2'b01);
      run(2000);
      cw_in = 1'b1;
      wait_lock();
      run(3);
      chk("dir_both", {cw_out, ccw_out}, 2'b00);
      run(2000);
      ccw_in = 1'b0;
      wait_lock();
      run(3);
      chk("dir_cw", {cw_out, ccw_out}, 2'b10);

      // negative amplitude, slow phase, then frozen phase
      run(2000);
      amplitude = -13'sd3000;
      frequency = 13'd64;
      run(2 * PERIOD);
      frequency = 13'd0;
      amplitude = 13'sd1500;
      run(2 * PERIOD);

      enable = 1'b0;
      tick();
      chk("disable_zero", {out1, out2, en1, en2}, 0);
      run(100);
      enable = 1'b1;
      run(100);

      // reset mid-operation
      reset_n = 1'b0;
      run(3);
      reset_n = 1'b1;
      frequency = 13'd5000;
      tick();
      chk("relock", lock, 1);
      run(PERIOD + 10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
